// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - client request/response and SRAM control pins of mem_arbiter
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19
);
    logic [NUM_PORTS-1:0]            PORT_REQ;
    logic [NUM_PORTS-1:0]            PORT_WE;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_ADDR;
    logic [NUM_PORTS*DATA_WIDTH-1:0] PORT_WDATA;
    logic [NUM_PORTS*DATA_WIDTH-1:0] PORT_RDATA;
    logic [NUM_PORTS-1:0]            PORT_ACK;
    logic                            MEM_ARB_BUSY;
    logic [ADDR_WIDTH-1:0]           MEMORY_ADDR;
    logic                            MEMORY_CE;
    logic                            MEMORY_OE;
    logic                            MEMORY_WE;

    modport master (
        output PORT_REQ, PORT_WE, PORT_ADDR, PORT_WDATA,
        input  PORT_RDATA, PORT_ACK, MEM_ARB_BUSY,
        input  MEMORY_ADDR, MEMORY_CE, MEMORY_OE, MEMORY_WE
    );

    modport slave (
        input  PORT_REQ, PORT_WE, PORT_ADDR, PORT_WDATA,
        output PORT_RDATA, PORT_ACK, MEM_ARB_BUSY,
        output MEMORY_ADDR, MEMORY_CE, MEMORY_OE, MEMORY_WE
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port round-robin arbiter for one async SRAM; MEM_ARB_PORT0_PRIO_EN gives port 0 strict priority
module mem_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  MEM_ARB_CLK,
    input  logic                  MEM_ARB_RST,
    mem_arbiter_if.slave          bus,
    inout  wire [DATA_WIDTH-1:0]  MEMORY_DATA
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]                      state;
    logic [3:0]                      wait_cnt;
    logic [IDX_W-1:0]                ptr;
    logic [IDX_W-1:0]                win;
    logic                            lat_we;
    logic [DATA_WIDTH-1:0]           lat_wdata;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic                            mem_ce;
    logic                            mem_oe;
    logic                            mem_we;
    logic                            busy;
    logic [NUM_PORTS-1:0]            ack;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;

    logic                            sel_valid;
    logic [IDX_W-1:0]                sel_idx;
    logic [IDX_W-1:0]                cand_idx;
    int                              cand;

    // Loops run from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
`ifdef MEM_ARB_PORT0_PRIO_EN
        for (int k = NUM_PORTS - 1; k >= 1; k--) begin
            cand     = 1 + ((int'(ptr) - 1 + k) % (NUM_PORTS - 1));
            cand_idx = IDX_W'(cand);
            if (bus.PORT_REQ[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        if (bus.PORT_REQ[0]) begin
            sel_valid = 1'b1;
            sel_idx   = '0;
        end
`else
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand     = (int'(ptr) + k) % NUM_PORTS;
            cand_idx = IDX_W'(cand);
            if (bus.PORT_REQ[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
`endif
    end

    always_ff @(posedge MEM_ARB_CLK) begin
        if (MEM_ARB_RST) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            ptr       <= IDX_W'(NUM_PORTS - 1);
            win       <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            mem_addr  <= '0;
            mem_ce    <= 1'b1;
            mem_oe    <= 1'b1;
            mem_we    <= 1'b1;
            busy      <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state     <= ST_ACCESS;
                        busy      <= 1'b1;
                        win       <= sel_idx;
                        lat_we    <= bus.PORT_WE[sel_idx];
                        lat_wdata <= bus.PORT_WDATA[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                        mem_addr  <= bus.PORT_ADDR[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        mem_ce    <= 1'b0;
                        mem_oe    <= bus.PORT_WE[sel_idx];
                        mem_we    <= ~bus.PORT_WE[sel_idx];
`ifdef MEM_ARB_PORT0_PRIO_EN
                        if (sel_idx != '0)
                            ptr <= sel_idx;
`else
                        ptr <= sel_idx;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_DONE;
                        mem_ce   <= 1'b1;
                        mem_oe   <= 1'b1;
                        mem_we   <= 1'b1;
                        ack[win] <= 1'b1;
                        // OE is still low on this edge, so the SRAM is driving valid data.
                        if (!lat_we)
                            rdata[int'(win)*DATA_WIDTH +: DATA_WIDTH] <= MEMORY_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write data stays on the bus through DONE to cover SRAM hold time after WE rises.
    assign MEMORY_DATA = (lat_we && (state == ST_ACCESS || state == ST_DONE))
                         ? lat_wdata : {DATA_WIDTH{1'bz}};

    assign bus.PORT_RDATA   = rdata;
    assign bus.PORT_ACK     = ack;
    assign bus.MEM_ARB_BUSY = busy;
    assign bus.MEMORY_ADDR  = mem_addr;
    assign bus.MEMORY_CE    = mem_ce;
    assign bus.MEMORY_OE    = mem_oe;
    assign bus.MEMORY_WE    = mem_we;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int AW = 19;
    localparam int WC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [DW-1:0] mem_data;
    int errors = 0;
    int checks = 0;

    mem_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .MEM_ARB_CLK (clk),
        .MEM_ARB_RST (rst),
        .bus         (bus),
        .MEMORY_DATA (mem_data)
    );

    always #5 clk = ~clk;

    // SRAM: unwritten locations read back as (addr ^ 0x55).
    bit [DW-1:0] sram [256];
    bit          sram_wr [256];
    logic [7:0]    sa;
    logic [DW-1:0] rd_val;
    assign sa       = bus.MEMORY_ADDR[7:0];
    assign rd_val   = sram_wr[sa] ? sram[sa] : (sa ^ 8'h55);
    assign mem_data = (!bus.MEMORY_CE && !bus.MEMORY_OE) ? rd_val : {DW{1'bz}};

    always @(posedge clk) begin
        if (!bus.MEMORY_CE && !bus.MEMORY_WE) begin
            sram[sa]    <= mem_data;
            sram_wr[sa] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [9];
    logic [DW-1:0]    exp_rd [NP];
    logic [NP*DW-1:0] exp_pk;
    int exp_order [5];

    initial begin
        int lat, strobe, got, acks, busy_cnt, n;
        bit addr_ok, data_ok;
        logic [NP-1:0] ack_seen;
        int ack_port [5];
        int ack_cyc [5];

        vecs[0] = '{1, 1'b1, 19'h00123, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 19'h00123, 8'h00, 8'hA5};
        vecs[2] = '{2, 1'b1, 19'h00045, 8'h3C, 8'h00};
        vecs[3] = '{3, 1'b0, 19'h00045, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b1, 19'h00123, 8'h0F, 8'h00};
        vecs[5] = '{1, 1'b0, 19'h00123, 8'h00, 8'h0F};
        vecs[6] = '{2, 1'b0, 19'h000FF, 8'h00, 8'hAA};
        vecs[7] = '{3, 1'b1, 19'h7FF01, 8'h99, 8'h00};
        vecs[8] = '{0, 1'b0, 19'h7FF01, 8'h00, 8'h99};
`ifdef MEM_ARB_PORT0_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NP; i++) exp_rd[i] = '0;

        bus.PORT_REQ   = '0;
        bus.PORT_WE    = '0;
        bus.PORT_ADDR  = '0;
        bus.PORT_WDATA = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {bus.MEMORY_CE, bus.MEMORY_OE, bus.MEMORY_WE}, 3'b111);
        check("reset_addr", bus.MEMORY_ADDR, 0);
        check("reset_ack", bus.PORT_ACK, 0);
        check("reset_rdata", bus.PORT_RDATA, 0);
        check("reset_busy", bus.MEM_ARB_BUSY, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            bus.PORT_REQ                            = '0;
            bus.PORT_REQ[vecs[v].port]              = 1'b1;
            bus.PORT_WE[vecs[v].port]               = vecs[v].we;
            bus.PORT_ADDR[vecs[v].port*AW +: AW]    = vecs[v].addr;
            bus.PORT_WDATA[vecs[v].port*DW +: DW]   = vecs[v].wdata;
            lat = 0; strobe = 0; got = 0; addr_ok = 1'b1; data_ok = 1'b1; ack_seen = '0;
            for (int c = 1; c <= 20 && got == 0; c++) begin
                @(posedge clk); @(negedge clk);
                if (!bus.MEMORY_CE && !(vecs[v].we ? bus.MEMORY_WE : bus.MEMORY_OE)) begin
                    strobe++;
                    if (bus.MEMORY_ADDR !== vecs[v].addr) addr_ok = 1'b0;
                    if (vecs[v].we && mem_data !== vecs[v].wdata) data_ok = 1'b0;
                end
                if (bus.PORT_ACK != '0) begin
                    got = 1; lat = c; ack_seen = bus.PORT_ACK;
                    if (bus.MEMORY_ADDR !== vecs[v].addr) addr_ok = 1'b0;
                    if (vecs[v].we && mem_data !== vecs[v].wdata) data_ok = 1'b0;
                    bus.PORT_REQ[vecs[v].port] = 1'b0;
                end
            end
            check($sformatf("v%0d_ack_seen", v), got, 1);
            check($sformatf("v%0d_latency", v), lat, WC + 2);
            check($sformatf("v%0d_ack_port", v), ack_seen, NP'(1) << vecs[v].port);
            check($sformatf("v%0d_strobe_width", v), strobe, WC + 1);
            check($sformatf("v%0d_addr", v), addr_ok, 1);
            if (vecs[v].we)
                check($sformatf("v%0d_wdata", v), data_ok, 1);
            else
                exp_rd[vecs[v].port] = vecs[v].rdata;
            for (int i = 0; i < NP; i++) exp_pk[i*DW +: DW] = exp_rd[i];
            check($sformatf("v%0d_rdata", v), bus.PORT_RDATA, exp_pk);
            @(negedge clk);
            check($sformatf("v%0d_ack_cleared", v), bus.PORT_ACK, 0);
            check($sformatf("v%0d_busy_cleared", v), bus.MEM_ARB_BUSY, 0);
        end

        // REQ dropped mid-access: the access still completes once, no regrant.
        @(posedge clk); #1;
        bus.PORT_REQ[2] = 1'b1; bus.PORT_WE[2] = 1'b0; bus.PORT_ADDR[2*AW +: AW] = 19'h00045;
        @(posedge clk); @(negedge clk);
        busy_cnt = int'(bus.MEM_ARB_BUSY);
        bus.PORT_REQ[2] = 1'b0;
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); @(negedge clk);
            acks += int'(bus.PORT_ACK[2]);
            busy_cnt += int'(bus.MEM_ARB_BUSY);
        end
        exp_rd[2] = 8'h3C;
        for (int i = 0; i < NP; i++) exp_pk[i*DW +: DW] = exp_rd[i];
        check("drop_req_ack_count", acks, 1);
        check("drop_req_busy_cycles", busy_cnt, WC + 2);
        check("drop_req_rdata", bus.PORT_RDATA, exp_pk);

        // Reset during the second ACCESS cycle aborts with no ACK.
        @(posedge clk); #1;
        bus.PORT_REQ[1] = 1'b1; bus.PORT_WE[1] = 1'b0; bus.PORT_ADDR[1*AW +: AW] = 19'h00123;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midreset_in_access", bus.MEMORY_CE, 0);
        @(posedge clk); @(negedge clk);
        check("midreset_strobes", {bus.MEMORY_CE, bus.MEMORY_OE, bus.MEMORY_WE}, 3'b111);
        check("midreset_busy", bus.MEM_ARB_BUSY, 0);
        check("midreset_ack", bus.PORT_ACK, 0);
        check("midreset_rdata", bus.PORT_RDATA, 0);
        @(posedge clk); #1 rst = 1'b0; bus.PORT_REQ = '0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.PORT_ACK != '0) acks++;
        end
        check("midreset_no_ack", acks, 0);

        // All ports requesting continuously from reset.
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < NP; i++) begin
            bus.PORT_WE[i] = 1'b0;
            bus.PORT_ADDR[i*AW +: AW] = AW'(16 * i);
        end
        bus.PORT_REQ = '1;
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        for (int c = 1; c <= 40 && n < 5; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.PORT_ACK != '0) begin
                ack_port[n] = -1;
                for (int i = 0; i < NP; i++) if (bus.PORT_ACK[i]) ack_port[n] = i;
                ack_cyc[n] = c;
                n++;
            end
        end
        check("rr_ack_count", n, 5);
        if (n == 5) begin
            check("rr_first_latency", ack_cyc[0], WC + 2);
            for (int i = 0; i < 5; i++)
                check($sformatf("rr_grant%0d", i), ack_port[i], exp_order[i]);
            for (int i = 1; i < 5; i++)
                check($sformatf("rr_period%0d", i), ack_cyc[i] - ack_cyc[i-1], WC + 3);
        end
        #1 bus.PORT_REQ = '0;
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port arbiter for the single external asynchronous SRAM, replacing the fixed two-port time-slice multiplexer. Each client port issues single-word read/write requests with a REQ/ACK handshake; the block grants one port at a time (round-robin), sequences the SRAM control strobes with a configurable access-wait count, and returns read data in a per-port holding register. It sits between the CPU/video/DMA clients and the board SRAM pins.

## Interface
- NUM_PORTS, 2: number of client ports (2..8).
- DATA_WIDTH, 8: SRAM data width.
- ADDR_WIDTH, 19: SRAM address width.
- WAIT_CYCLES, 1: extra ACCESS cycles for SRAM access time (0..15).

- MEM_ARB_CLK  in  1  single clock; all logic on rising edge.
- MEM_ARB_RST  in  1  synchronous, active-high reset.
- PORT_REQ  in  NUM_PORTS  per-port request, held until ACK.
- PORT_WE  in  NUM_PORTS  per-port 1 = write, 0 = read.
- PORT_ADDR  in  NUM_PORTS*ADDR_WIDTH  port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- PORT_WDATA  in  NUM_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH].
- PORT_RDATA  out  NUM_PORTS*DATA_WIDTH  per-port registered read data.
- PORT_ACK  out  NUM_PORTS  one-cycle completion pulse per port.
- MEM_ARB_BUSY  out  1  high whenever state ≠ IDLE.
- MEMORY_DATA  inout  DATA_WIDTH  SRAM data bus.
- MEMORY_ADDR  out  ADDR_WIDTH  SRAM address.
- MEMORY_CE  out  1  active-low chip enable.
- MEMORY_OE  out  1  active-low output enable.
- MEMORY_WE  out  1  active-low write enable.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any PORT_REQ high, select winner, latch its ADDR/WE/WDATA and index, load wait counter with WAIT_CYCLES, go ACCESS. Otherwise stay.
- ACCESS: MEMORY_CE low; read: MEMORY_OE low; write: MEMORY_WE low, MEMORY_DATA driven with latched WDATA. Counter decrements each cycle; at 0 go DONE. Read: MEMORY_DATA captured into winner's PORT_RDATA on the clock edge leaving ACCESS.
- DONE: MEMORY_CE/OE/WE high; write data still driven (hold time); MEMORY_ADDR unchanged; PORT_ACK[winner] high for this cycle only; go IDLE.
- MEMORY_DATA is hi-Z except ACCESS/DONE of a write.
- Round-robin: pointer holds last granted index; search starts at pointer+1 modulo NUM_PORTS; pointer updated on grant.
- PORT_RDATA of port i changes only on completion of a read by port i; writes and other ports leave it untouched.
- REQ sampled only in IDLE; REQ dropping mid-access does not abort — access completes and ACK still pulses.
- Requester wanting no further access drops REQ on the edge where it samples ACK; REQ still high in the following IDLE is a new request.
- Reset values: state IDLE, MEMORY_CE/OE/WE = 1, MEMORY_ADDR = 0, MEMORY_DATA hi-Z, PORT_ACK = 0, PORT_RDATA = 0, MEM_ARB_BUSY = 0, pointer = NUM_PORTS-1 (port 0 wins first). Reset mid-access aborts immediately with these values; no ACK is issued.

## Timing
- REQ high in IDLE cycle t → ACCESS cycles t+1..t+1+WAIT_CYCLES → DONE/ACK at cycle t+WAIT_CYCLES+2.
- Access period WAIT_CYCLES+3 cycles; back-to-back grants separated by one IDLE cycle.
- WE/OE low pulse width WAIT_CYCLES+1 cycles; address valid ≥1 cycle before ACCESS ends and 1 cycle after strobes rise.
- PORT_RDATA valid in ACK cycle and held thereafter.
- All outputs registered except MEMORY_DATA tri-state enable (decoded from registered state/WE).

## Configuration
- MEM_ARB_PORT0_PRIO_EN defined: port 0 wins whenever it requests in IDLE (video refresh); remaining ports round-robin among 1..NUM_PORTS-1; pointer not updated by port-0 grants.
- Undefined: pure round-robin over all ports.

## Test plan
- WAIT_CYCLES=1, port 1 write addr 0x00123 data 0xA5 → MEMORY_WE low 2 cycles, MEMORY_ADDR 0x00123, MEMORY_DATA 0xA5, PORT_ACK[1] at t+3.
- Port 0 read 0x00123 from SRAM model → PORT_RDATA[7:0] = 0xA5 at ACK; PORT_RDATA of port 1 unchanged.
- NUM_PORTS=4, all REQ held high from reset → grant order 0,1,2,3,0, each access 4 cycles, one IDLE gap between.
- MEM_ARB_PORT0_PRIO_EN, ports 0 and 2 held high → port 0 granted every access; port 2 never (starvation intended); drop port 0 REQ → port 2 next.
- MEM_ARB_RST asserted in second ACCESS cycle → next cycle CE/OE/WE = 1, data hi-Z, no ACK, BUSY = 0.
- REQ dropped during ACCESS → access completes, ACK pulses once, no regrant.
